// File: rtl/mult_sched_if.sv
// Handshake/operand bundle between the operand sources and the mult_sched
// scheduler. The scheduler uses the slave view; the sources use the master view.
interface mult_sched_if #(
    parameter int SIZE_C = 4
);
    logic                  req0;
    logic [SIZE_C-1:0]     m0;
    logic [SIZE_C-1:0]     c0;
    logic                  req1;
    logic [SIZE_C-1:0]     m1;
    logic [SIZE_C-1:0]     c1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  done0;
    logic                  done1;
    logic [2*SIZE_C-1:0]   prod;
    logic                  busy;

    modport slave (
        input  req0, m0, c0, req1, m1, c1,
        output gnt0, gnt1, done0, done1, prod, busy
    );

    modport master (
        output req0, m0, c0, req1, m1, c1,
        input  gnt0, gnt1, done0, done1, prod, busy
    );
endinterface

// File: rtl/mult_sched.sv
// Two-requester round-robin scheduler sharing one combinational MULT.
// One operation takes three cycles: grant/latch, product capture + done, release.

// Combinational unsigned multiplier shared by both requesters.
module MULT #(
    parameter int SIZE_C = 4
) (
    input  logic [SIZE_C-1:0]   M,
    input  logic [SIZE_C-1:0]   C,
    output logic [2*SIZE_C-1:0] out
);
    assign out = {{SIZE_C{1'b0}}, M} * {{SIZE_C{1'b0}}, C};
endmodule

module mult_sched #(
    parameter int SIZE_C = 4
) (
    input logic         clk,
    input logic         rst,
    mult_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;   // requester granted most recently
    logic                win_q, win_d;     // requester owning the current operation
    logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                done0_q, done0_d, done1_q, done1_d;
    logic                busy_q, busy_d;
    logic [SIZE_C-1:0]   opm_q, opm_d, opc_q, opc_d;
    logic [2*SIZE_C-1:0] prod_q, prod_d;
    logic [2*SIZE_C-1:0] mult_out;

    MULT #(.SIZE_C(SIZE_C)) u_mult (
        .M   (opm_q),
        .C   (opc_q),
        .out (mult_out)
    );

    // State and output registers; reset aborts any operation without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
            opm_q   <= '0;
            opc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
            opm_q   <= opm_d;
            opc_q   <= opc_d;
            prod_q  <= prod_d;
        end
    end

    // Next-state: arbitrate in IDLE, capture product in MUL, release in DONE.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        done0_d = done0_q;
        done1_d = done1_q;
        busy_d  = busy_q;
        opm_d   = opm_q;
        opc_d   = opc_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On contention the requester not served last wins.
                    win_d   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    opm_d   = win_d ? bus.m1 : bus.m0;
                    opc_d   = win_d ? bus.c1 : bus.c0;
                    gnt0_d  = ~win_d;
                    gnt1_d  = win_d;
                    busy_d  = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                prod_d  = mult_out;
                done0_d = ~win_q;
                done1_d = win_q;
                state_d = DONE;
            end
            DONE: begin
                done0_d = 1'b0;
                done1_d = 1'b0;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                busy_d  = 1'b0;
                last_d  = win_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.done0 = done0_q;
    assign bus.done1 = done1_q;
    assign bus.prod  = prod_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: directed scenarios plus randomized requesters, all
// outputs compared every cycle against a transaction-level ownership model.
module tb_mult_sched;
    logic clk;
    logic rst;

    mult_sched_if #(.SIZE_C(4)) bus ();

    mult_sched #(.SIZE_C(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrs   = 0;
    int cyc     = 0;

    // Reference model: who owns the multiplier and for how many more edges.
    int own_left;   // 0: free (next edge samples), 2: just granted, 1: done showing
    int owner;
    int last_win;
    int pend_prod;
    int e_gnt0, e_gnt1, e_done0, e_done1, e_busy, e_prod;

    // Observed done events, for directed ordering/period checks.
    int ev_who[$];
    int ev_prod[$];
    int ev_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        own_left = 0;
        owner    = 0;
        last_win = 1;
        e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0; e_busy = 0; e_prod = 0;
    endtask

    // Advance the model across one rising edge using the inputs present at it.
    task automatic model_edge();
        if (own_left == 0) begin
            if (bus.req0 || bus.req1) begin
                if (bus.req0 && bus.req1) owner = (last_win == 0) ? 1 : 0;
                else                      owner = bus.req1 ? 1 : 0;
                pend_prod = (owner == 0) ? int'(bus.m0) * int'(bus.c0)
                                         : int'(bus.m1) * int'(bus.c1);
                own_left = 2;
                e_gnt0 = (owner == 0); e_gnt1 = (owner == 1); e_busy = 1;
            end
        end else if (own_left == 2) begin
            own_left = 1;
            e_prod  = pend_prod;
            e_done0 = (owner == 0);
            e_done1 = (owner == 1);
        end else begin
            own_left = 0;
            last_win = owner;
            e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0; e_busy = 0;
        end
    endtask

    task automatic check_outputs();
        check("gnt0",  32'(bus.gnt0),  32'(e_gnt0));
        check("gnt1",  32'(bus.gnt1),  32'(e_gnt1));
        check("done0", 32'(bus.done0), 32'(e_done0));
        check("done1", 32'(bus.done1), 32'(e_done1));
        check("busy",  32'(bus.busy),  32'(e_busy));
        check("prod",  32'(bus.prod),  32'(e_prod));
    endtask

    // One clock: entered and left just after a falling edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (bus.done0) begin ev_who.push_back(0); ev_prod.push_back(int'(bus.prod)); ev_cyc.push_back(cyc); end
        if (bus.done1) begin ev_who.push_back(1); ev_prod.push_back(int'(bus.prod)); ev_cyc.push_back(cyc); end
        @(negedge clk);
    endtask

    // Run n cycles; a requester not told to hold drops its req on its done.
    task automatic run(input int n, input bit hold0, input bit hold1);
        for (int i = 0; i < n; i++) begin
            cycle();
            if (e_done0 != 0 && !hold0) bus.req0 = 1'b0;
            if (e_done1 != 0 && !hold1) bus.req1 = 1'b0;
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_log();
        ev_who.delete();
        ev_prod.delete();
        ev_cyc.delete();
    endtask

    initial begin
        rst = 1'b1;
        bus.req0 = 1'b0; bus.m0 = '0; bus.c0 = '0;
        bus.req1 = 1'b0; bus.m1 = '0; bus.c1 = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single requester 0: 3*5
        clear_log();
        bus.req0 = 1'b1; bus.m0 = 4'd3; bus.c0 = 4'd5;
        run(5, 1'b0, 1'b0);
        check("t1_n", 32'(ev_who.size()), 32'd1);
        check("t1_who", 32'(ev_who[0]), 32'd0);
        check("t1_prod", 32'(ev_prod[0]), 32'd15);

        // Simultaneous requests after reset: 0 first, then 1, three cycles apart
        do_reset();
        clear_log();
        bus.req0 = 1'b1; bus.m0 = 4'd2; bus.c0 = 4'd7;
        bus.req1 = 1'b1; bus.m1 = 4'd4; bus.c1 = 4'd6;
        run(8, 1'b0, 1'b0);
        check("t2_n", 32'(ev_who.size()), 32'd2);
        check("t2_who0", 32'(ev_who[0]), 32'd0);
        check("t2_prod0", 32'(ev_prod[0]), 32'd14);
        check("t2_who1", 32'(ev_who[1]), 32'd1);
        check("t2_prod1", 32'(ev_prod[1]), 32'd24);
        check("t2_gap", 32'(ev_cyc[1] - ev_cyc[0]), 32'd3);

        // Both held continuously: six alternating grants
        clear_log();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        run(18, 1'b1, 1'b1);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        run(2, 1'b0, 1'b0);
        check("t3_n", 32'(ev_who.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check("t3_alt", 32'(ev_who[i]), 32'(i % 2));

        // Boundary operands
        clear_log();
        bus.req1 = 1'b1; bus.m1 = 4'd15; bus.c1 = 4'd15;
        run(4, 1'b0, 1'b0);
        bus.req0 = 1'b1; bus.m0 = 4'd0; bus.c0 = 4'd9;
        run(4, 1'b0, 1'b0);
        check("t4_n", 32'(ev_who.size()), 32'd2);
        check("t4_max", 32'(ev_prod[0]), 32'd225);
        check("t4_zero", 32'(ev_prod[1]), 32'd0);

        // Reset while in MUL: no done, then normal service with req0 priority
        clear_log();
        bus.req1 = 1'b1; bus.m1 = 4'd5; bus.c1 = 4'd5;
        cycle();
        check("t5_gnt", 32'(bus.gnt1), 32'd1);
        do_reset();
        bus.req1 = 1'b0;
        run(3, 1'b0, 1'b0);
        check("t5_nodone", 32'(ev_who.size()), 32'd0);
        bus.req0 = 1'b1; bus.m0 = 4'd9; bus.c0 = 4'd3;
        bus.req1 = 1'b1; bus.m1 = 4'd2; bus.c1 = 4'd2;
        run(7, 1'b0, 1'b0);
        check("t5_who", 32'(ev_who[0]), 32'd0);
        check("t5_prod", 32'(ev_prod[0]), 32'd27);

        // Operand changes after E0 must not leak into the product
        clear_log();
        bus.req0 = 1'b1; bus.m0 = 4'd6; bus.c0 = 4'd7;
        cycle();
        bus.m0 = 4'd15; bus.c0 = 4'd15;
        run(3, 1'b0, 1'b0);
        check("t6_prod", 32'(ev_prod[0]), 32'd42);

        // Repeated req1-only requests at a three-cycle period
        clear_log();
        bus.req1 = 1'b1; bus.m1 = 4'd3; bus.c1 = 4'd9;
        run(9, 1'b1, 1'b1);
        bus.req1 = 1'b0;
        run(2, 1'b0, 1'b0);
        check("t6_n", 32'(ev_who.size()), 32'd3);
        check("t6_per1", 32'(ev_cyc[1] - ev_cyc[0]), 32'd3);
        check("t6_per2", 32'(ev_cyc[2] - ev_cyc[1]), 32'd3);

        // Randomized requesters with operands changing every cycle
        for (int i = 0; i < 500; i++) begin
            bus.m0 = 4'($urandom_range(0, 15));
            bus.c0 = 4'($urandom_range(0, 15));
            bus.m1 = 4'($urandom_range(0, 15));
            bus.c1 = 4'($urandom_range(0, 15));
            if (!bus.req0)                                  bus.req0 = 1'($urandom_range(0, 1));
            else if (e_done0 != 0)                          bus.req0 = ($urandom_range(0, 3) == 0);
            else if (e_gnt0 == 0 && $urandom_range(0, 19) == 0) bus.req0 = 1'b0;
            if (!bus.req1)                                  bus.req1 = 1'($urandom_range(0, 1));
            else if (e_done1 != 0)                          bus.req1 = ($urandom_range(0, 3) == 0);
            else if (e_gnt1 == 0 && $urandom_range(0, 19) == 0) bus.req1 = 1'b0;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end
endmodule
